gpio_event_tx: RTL and testbench
================================

// Module: gpio_event_tx
// PURPOSE
//  Consumes the debounced GPIO vector (buttons + switches) that the top level produces
//  for fpga_core, and turns each input change into an ASCII event message.
//  Messages go out on an 8-bit AXI-stream master that feeds the UART transmitter
//  input in fpga_core. Message per event: 'A'+index, '0'/'1' level, CR (optional), LF.
// PARAMETERS
//  WIDTH     13  number of monitored inputs; legal range 1..26 (IDs 'A'..'Z')
//  EOL_CRLF  1   1: terminate with CR,LF (4-byte msg); 0: LF only (3-byte msg)
// PORTS
//  clk            in   1      system clock (125 MHz in the FPGA build)
//  reset_n        in   1      asynchronous active-low reset
//  in             in   WIDTH  debounced, already-synchronous GPIO levels
//  m_axis_tdata   out  8      message byte
//  m_axis_tvalid  out  1      byte valid
//  m_axis_tready  in   1      downstream (UART tx) ready
//  overrun        out  1      sticky: an event was merged before it was sent
//  overrun_clr    in   1      synchronous clear of overrun (set has priority)
//  busy           out  1      high while a message is in progress (FSM != IDLE)
// BEHAVIOUR
//  Reset: async assert clears all regs; tvalid=0, tdata=8'h00, overrun=0, busy=0,
//   prev=0, pending=0, armed=0. Mid-message reset aborts it; nothing resumes.
//  Arming: first clk edge after reset release loads prev<=in, sets armed, and
//   generates no events. This means levels present at reset produce no message.
//  Edge detect (armed): chg = in ^ prev; at every edge prev<=in and
//   pending <= (pending & ~clr_mask) | chg. clr_mask is the bit being selected by the FSM.
//  Merge: if chg[i] & pending[i] & ~clr_mask[i], set overrun. The pending bit stays
//   set and only one message goes out. On the same bit, set wins over clear, without overrun.
//  FSM states: IDLE, S_ID, S_LVL, S_CR, S_LF.
//   IDLE: when pending!=0, select lowest set index i. Latch idx=i, lvl=prev[i]
//    (post-edge level), clear pending[i], load tdata='A'+i, tvalid<=1 -> S_ID.
//   S_ID  -> S_LVL on tvalid&tready; tdata<=8'h30+lvl.
//   S_LVL -> S_CR (tdata<=8'h0D) if EOL_CRLF, else S_LF (tdata<=8'h0A).
//   S_CR  -> S_LF on handshake; tdata<=8'h0A.
//   S_LF  -> IDLE on handshake; tvalid<=0. At least 1 idle cycle between messages.
//  AXI rules: tvalid never drops and tdata never changes until the handshake.
//   A registered output is required; no combinational path from tready to tvalid.
//  Latency: in changes before edge k -> pending set at k -> tvalid=1 with ID byte after k+1.
//  Level reported is the level at selection time. If the input toggles back
//   before selection, the message reports the current level (e.g. '0' after 0->1->0).
//  Simultaneous changes: all go into pending and are served lowest index first.
//  in changes during a message: captured in pending, served after LF.
//  busy = (state != IDLE). overrun_clr and a new merge in the same cycle -> overrun=1.
// TESTING
//  1 in=13'h1FFF during reset, release, hold 100 cycles -> no tvalid, overrun=0.
//  2 in[0] 0->1, tready=1 -> bytes 41,31,0D,0A; first tvalid 2 cycles after change.
//  3 in[3],in[1] rise same cycle -> 42,31,0D,0A then 44,31,0D,0A; busy low 1 cycle between.
//  4 tready=0 for 10 cycles after ID byte -> tdata holds 41, tvalid stays 1, no loss.
//  5 while sending bit 0, toggle in[2] 0->1->0 -> overrun=1; one msg 43,30,0D,0A;
//    overrun_clr pulse -> overrun=0.
//  6 reset_n low mid-message (after byte 31) -> tvalid=0 immediately; after release no resume.
//  7 EOL_CRLF=0, in[12] 1->0 -> bytes 4D,30,0A only.

Source files
------------

// File: rtl/gpio_event_tx.sv
// gpio_event_tx
//   Watches a vector of debounced GPIO levels and, for every change, emits an
//   ASCII event message on an 8-bit AXI-stream master (toward the UART tx):
//   'A'+index, '0'/'1' current level, optional CR, then LF.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   in             debounced, already-synchronous GPIO levels (WIDTH bits)
//   m_axis_tdata   message byte (registered)
//   m_axis_tvalid  byte valid (registered)
//   m_axis_tready  downstream ready
//   overrun        sticky flag: a change was merged into a still-pending event
//   overrun_clr    synchronous clear of overrun (a new merge wins)
//   busy           high while a message is in progress
module gpio_event_tx #(
    parameter int unsigned WIDTH    = 13,
    parameter bit          EOL_CRLF = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             overrun,
    input  logic             overrun_clr,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        S_ID,
        S_LVL,
        S_CR,
        S_LF
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             armed_q;
    logic             lvl_q, lvl_d;
    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             overrun_q, overrun_d;

    logic             sel_found;
    logic [4:0]       sel_idx;
    logic             sel_lvl;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] chg;
    logic             merge;
    logic             hs;

    // Lowest-index pending event; only taken while idle. clr_mask is one-hot
    // for the bit being taken this cycle, zero otherwise.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_lvl   = 1'b0;
        clr_mask  = '0;
        if (state_q == IDLE) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (!sel_found && pending_q[i]) begin
                    sel_found   = 1'b1;
                    sel_idx     = 5'(i);
                    sel_lvl     = prev_q[i];
                    clr_mask[i] = 1'b1;
                end
            end
        end
    end

    // Before arming, prev simply tracks in and no change is reported, so the
    // levels present at reset release never generate a message.
    always_comb begin
        chg       = armed_q ? (in ^ prev_q) : '0;
        prev_d    = in;
        // A change on the bit being taken re-sets it (set wins over clear);
        // that is a fresh event, not a merge.
        pending_d = (pending_q & ~clr_mask) | chg;
        merge     = |(chg & pending_q & ~clr_mask);
        if (merge) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign hs = tvalid_q & m_axis_tready;

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        lvl_d    = lvl_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    lvl_d    = sel_lvl;
                    tdata_d  = 8'h41 + {3'b000, sel_idx};
                    tvalid_d = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                if (hs) begin
                    tdata_d = 8'h30 + {7'b0000000, lvl_q};
                    state_d = S_LVL;
                end
            end
            S_LVL: begin
                if (hs) begin
                    if (EOL_CRLF) begin
                        tdata_d = 8'h0D;
                        state_d = S_CR;
                    end else begin
                        tdata_d = 8'h0A;
                        state_d = S_LF;
                    end
                end
            end
            S_CR: begin
                if (hs) begin
                    tdata_d = 8'h0A;
                    state_d = S_LF;
                end
            end
            S_LF: begin
                if (hs) begin
                    tvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                tvalid_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            armed_q   <= 1'b0;
            lvl_q     <= 1'b0;
            tdata_q   <= 8'h00;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            armed_q   <= 1'b1;
            lvl_q     <= lvl_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_event_tx.sv
module tb_gpio_event_tx;

    localparam int unsigned W = 13;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_v;
    logic         tready;
    logic         oclr;

    logic [7:0] tdata0, tdata1;
    logic       tvalid0, tvalid1, ov0, ov1, busy0, busy1;

    always #5 clk = ~clk;

    // DUT 0: CR,LF terminator; DUT 1: LF only. Both see the same stimulus.
    gpio_event_tx #(.WIDTH(W), .EOL_CRLF(1'b1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in(in_v),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(tready),
        .overrun(ov0), .overrun_clr(oclr), .busy(busy0)
    );

    gpio_event_tx #(.WIDTH(W), .EOL_CRLF(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in(in_v),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
        .overrun(ov1), .overrun_clr(oclr), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a set of pending input IDs, last seen levels, and the
    // number of bytes of the current message still to be accepted.
    logic [W-1:0] m_prev [2] = '{default: '0};
    logic [W-1:0] m_pend [2] = '{default: '0};
    int unsigned  m_left [2] = '{default: 0};
    bit           m_armed[2] = '{default: 1'b0};
    bit           m_ov   [2] = '{default: 1'b0};
    logic [7:0]   q0[$];
    logic [7:0]   q1[$];
    logic [W-1:0] m_chg, m_clr;

    function automatic void push_byte(int d, logic [7:0] b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < 2; d++) begin
                m_prev[d]  = '0;
                m_pend[d]  = '0;
                m_left[d]  = 0;
                m_armed[d] = 1'b0;
                m_ov[d]    = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_armed[d]) begin
                    m_prev[d]  = in_v;
                    m_armed[d] = 1'b1;
                end else begin
                    m_clr = '0;
                    if (m_left[d] == 0) begin
                        for (int i = 0; i < W; i++) begin
                            if (m_pend[d][i] && m_clr == '0) begin
                                m_clr[i] = 1'b1;
                                push_byte(d, 8'h41 + 8'(i));
                                push_byte(d, m_prev[d][i] ? 8'h31 : 8'h30);
                                if (d == 0) push_byte(d, 8'h0D);
                                push_byte(d, 8'h0A);
                                m_left[d] = (d == 0) ? 4 : 3;
                            end
                        end
                    end else if (tready) begin
                        m_left[d] = m_left[d] - 1;
                    end
                    m_chg = in_v ^ m_prev[d];
                    if ((m_chg & m_pend[d] & ~m_clr) != '0) m_ov[d] = 1'b1;
                    else if (oclr)                           m_ov[d] = 1'b0;
                    m_pend[d] = (m_pend[d] & ~m_clr) | m_chg;
                    m_prev[d] = in_v;
                end
            end
        end
    end

    task automatic cmp(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Monitor: on the falling edge, compare flags against the model and the
    // presented byte against the scoreboard head; pop on handshake.
    task automatic mon(int d, logic v, logic [7:0] data, logic b, logic o);
        logic [7:0] exp_b;
        cmp("tvalid", d, {31'b0, v}, {31'b0, m_left[d] != 0});
        cmp("busy",   d, {31'b0, b}, {31'b0, m_left[d] != 0});
        cmp("overrun", d, {31'b0, o}, {31'b0, m_ov[d]});
        if (v === 1'b1) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                errors++;
                $display("FAIL byte dut%0d t=%0t: got %0h expected none", d, $time, data);
            end else begin
                exp_b = (d == 0) ? q0[0] : q1[0];
                cmp("byte", d, {24'b0, data}, {24'b0, exp_b});
                if (tready) begin
                    if (d == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, tvalid0, tdata0, busy0, ov0);
        mon(1, tvalid1, tdata1, busy1, ov1);
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(logic [W-1:0] lv);
        reset_n = 1'b0;
        in_v    = lv;
        #1;
        cmp("rst_tdata", 0, {24'b0, tdata0}, 32'h00);
        cmp("rst_tvalid", 1, {31'b0, tvalid1}, 32'h0);
        step(3);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((m_left[0] != 0 || m_left[1] != 0 || m_pend[0] != '0 || m_pend[1] != '0)
               && n < 400) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s: model still busy after %0d cycles, expected idle", name, n);
        end
        step(2);
    endtask

    initial begin
        tready = 1'b1;
        oclr   = 1'b0;

        // Levels held through reset produce nothing.
        do_reset('1);
        step(100);

        // Single rise, then two simultaneous rises.
        do_reset('0);
        step(2);
        in_v[0] = 1'b1;
        step(1);
        wait_idle("single");
        in_v[3] = 1'b1;
        in_v[1] = 1'b1;
        step(1);
        wait_idle("pair");

        // Backpressure right after the ID byte.
        in_v[4] = 1'b1;
        step(2);
        tready = 1'b0;
        step(10);
        tready = 1'b1;
        wait_idle("stall");

        // Pulse on bit 2 while bit 0 is being sent -> merge.
        in_v[0] = 1'b0;
        step(2);
        in_v[2] = 1'b1;
        step(1);
        in_v[2] = 1'b0;
        step(1);
        wait_idle("merge");
        oclr = 1'b1;
        step(1);
        oclr = 1'b0;
        step(2);

        // Reset after the level byte is accepted; nothing resumes.
        in_v[5] = 1'b1;
        begin
            int n = 0;
            while (m_left[0] != 2 && n < 20) begin
                step(1);
                n++;
            end
            checks++;
            if (n >= 20) begin
                errors++;
                $display("FAIL midmsg: no level byte after %0d cycles, expected within 20", n);
            end
        end
        reset_n = 1'b0;
        #1;
        cmp("abort_tvalid", 0, {31'b0, tvalid0}, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(20);

        // Bit 12 rise then fall (LF-only on dut1: 4D,30,0A).
        in_v[12] = 1'b1;
        step(1);
        wait_idle("b12_rise");
        in_v[12] = 1'b0;
        step(1);
        wait_idle("b12_fall");

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) in_v[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) in_v[$urandom_range(0, W - 1)] ^= 1'b1;
            tready = ($urandom_range(0, 3) != 0);
            oclr   = ($urandom_range(0, 15) == 0);
            step(1);
        end
        tready = 1'b1;
        oclr   = 1'b0;
        wait_idle("drain");
        cmp("q0_empty", 0, q0.size(), 0);
        cmp("q1_empty", 1, q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
